// File: rtl/alu_pkg.sv
// Shared opcode encoding and default operand width for the ESC datapath ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_NOR = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor shared by ADD, SUB and SLT.
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             lt_signed
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   ext;

    always_comb begin
        b_eff = sub ? ~b : b;
        ext   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum   = ext[WIDTH-1:0];
        // For subtraction the raw carry is the inverse of the borrow.
        carry_out = sub ? ~ext[WIDTH] : ext[WIDTH];
        overflow  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        // Sign of the true difference: correct even when A - B overflows.
        lt_signed = sum[WIDTH-1] ^ overflow;
    end

endmodule

// File: rtl/alu16.sv
// Registered 16-bit ALU: operation mux, flag generation and one output register stage.
module alu16
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       control,
    output logic             out_valid,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] as_sum;
    logic             as_sub, as_carry, as_ovf, as_lt;

    logic [WIDTH-1:0] result_p0;
    logic             carry_p0, ovf_p0;

    logic [WIDTH-1:0] out_p1;
    logic             zero_p1, carry_p1, ovf_p1, neg_p1, vld_p1;

    assign as_sub = (control == OP_SUB) || (control == OP_SLT);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a         (A),
        .b         (B),
        .sub       (as_sub),
        .sum       (as_sum),
        .carry_out (as_carry),
        .overflow  (as_ovf),
        .lt_signed (as_lt)
    );

    // Stage p0: operation select and carry/overflow qualification
    always_comb begin
        result_p0 = '0;
        carry_p0  = 1'b0;
        ovf_p0    = 1'b0;
        case (control)
            OP_AND: result_p0 = A & B;
            OP_OR:  result_p0 = A | B;
            OP_ADD: begin
                result_p0 = as_sum;
                carry_p0  = as_carry;
                ovf_p0    = as_ovf;
            end
            OP_SUB: begin
                result_p0 = as_sum;
                carry_p0  = as_carry;
                ovf_p0    = as_ovf;
            end
            OP_XOR: result_p0 = A ^ B;
            OP_SLT: result_p0 = {{(WIDTH-1){1'b0}}, as_lt};
            OP_NOR: result_p0 = ~(A | B);
            OP_SLL: result_p0 = A << B[SHW-1:0];
            default: result_p0 = '0;
        endcase
    end

    // Stage p1: output register; results and flags hold while no new operation arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            out_p1   <= '0;
            zero_p1  <= 1'b0;
            carry_p1 <= 1'b0;
            ovf_p1   <= 1'b0;
            neg_p1   <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                out_p1   <= result_p0;
                zero_p1  <= (result_p0 == '0);
                carry_p1 <= carry_p0;
                ovf_p1   <= ovf_p0;
                neg_p1   <= result_p0[WIDTH-1];
            end
        end
    end

    assign out_valid = vld_p1;
    assign Out       = out_p1;
    assign Zero      = zero_p1;
    assign Carry     = carry_p1;
    assign Overflow  = ovf_p1;
    assign Negative  = neg_p1;

endmodule

// File: tb/tb_alu16.sv
// Directed self-checking bench for alu16: reset, opcodes, boundaries, streaming and hold.
module tb_alu16;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] r;
        logic [3:0]  f;   // {Zero, Carry, Overflow, Negative}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [2:0]  control = '0;
    logic        out_valid;
    logic [15:0] Out;
    logic        Zero, Carry, Overflow, Negative;

    int checks = 0;
    int errors = 0;

    alu16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .control   (control),
        .out_valid (out_valid),
        .Out       (Out),
        .Zero      (Zero),
        .Carry     (Carry),
        .Overflow  (Overflow),
        .Negative  (Negative)
    );

    always #5 clk = ~clk;

    task automatic issue(input vec_t v);
        @(negedge clk);
        A        = v.a;
        B        = v.b;
        control  = v.op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; A = 16'hFFFF; B = 16'h0001; control = OP_ADD;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, Out, Zero, Carry, Overflow, Negative} !== 21'h0) begin
                errors++;
                $display("FAIL reset cyc%0d: got vld=%b out=%h zcvn=%b%b%b%b, want vld=0 out=0000 zcvn=0000",
                         i, out_valid, Out, Zero, Carry, Overflow, Negative);
            end
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic run_table(input string name, input vec_t v [], input int n);
        for (int i = 0; i < n; i++) begin
            issue(v[i]);
            checks++;
            if ({out_valid, Out, Zero, Carry, Overflow, Negative} !== {1'b1, v[i].r, v[i].f}) begin
                errors++;
                $display("FAIL %s[%0d] a=%h b=%h op=%b: got vld=%b out=%h zcvn=%b%b%b%b, want vld=1 out=%h zcvn=%b",
                         name, i, v[i].a, v[i].b, v[i].op, out_valid, Out,
                         Zero, Carry, Overflow, Negative, v[i].r, v[i].f);
            end
        end
    endtask

    task automatic test_arith();
        vec_t v [] = '{
            '{16'h0001, 16'h0002, OP_ADD, 16'h0003, 4'b0000},
            '{16'h0004, 16'h0002, OP_SUB, 16'h0002, 4'b0000},
            '{16'h0002, 16'h0004, OP_SUB, 16'hFFFE, 4'b0101},
            '{16'h0005, 16'h0005, OP_SUB, 16'h0000, 4'b1000}
        };
        run_table("arith", v, 4);
    endtask

    task automatic test_logic();
        vec_t v [] = '{
            '{16'hF333, 16'h0CCC, OP_AND, 16'h0000, 4'b1000},
            '{16'hF333, 16'h0CCC, OP_OR,  16'hFFFF, 4'b0001},
            '{16'hF333, 16'h0CCC, OP_XOR, 16'hFFFF, 4'b0001},
            '{16'hF333, 16'h0CCC, OP_NOR, 16'h0000, 4'b1000},
            '{16'hFF00, 16'h0FF0, OP_AND, 16'h0F00, 4'b0000},
            '{16'hFF00, 16'h0FF0, OP_XOR, 16'hF0F0, 4'b0001}
        };
        run_table("logic", v, 6);
    endtask

    task automatic test_boundary();
        vec_t v [] = '{
            '{16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 4'b0011},
            '{16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 4'b1100},
            '{16'h8000, 16'h0001, OP_SUB, 16'h7FFF, 4'b0010},
            '{16'h8000, 16'h8000, OP_ADD, 16'h0000, 4'b1110}
        };
        run_table("boundary", v, 4);
    endtask

    task automatic test_slt_sll();
        vec_t v [] = '{
            '{16'h0001, 16'h0001, OP_SLT, 16'h0000, 4'b1000},
            '{16'h8000, 16'h0001, OP_SLT, 16'h0001, 4'b0000},
            '{16'h7FFF, 16'h8000, OP_SLT, 16'h0000, 4'b1000},
            '{16'hFFFF, 16'h0001, OP_SLT, 16'h0001, 4'b0000},
            '{16'h0001, 16'h0013, OP_SLL, 16'h0008, 4'b0000},
            '{16'h8001, 16'h000F, OP_SLL, 16'h8000, 4'b0001},
            '{16'h1234, 16'h0010, OP_SLL, 16'h1234, 4'b0000}
        };
        run_table("slt_sll", v, 7);
    endtask

    task automatic test_back_to_back();
        vec_t v [] = '{
            '{16'h0010, 16'h0020, OP_ADD, 16'h0030, 4'b0000},
            '{16'h0100, 16'h0001, OP_SUB, 16'h00FF, 4'b0000},
            '{16'h00F0, 16'h000F, OP_OR,  16'h00FF, 4'b0000},
            '{16'h0003, 16'h0004, OP_SLL, 16'h0030, 4'b0000}
        };
        run_table("b2b", v, 4);
        // Drop in_valid with garbage on the operands; outputs must hold.
        @(negedge clk);
        in_valid = 1'b0; A = 16'hFFFF; B = 16'hFFFF; control = OP_ADD;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, Out, Zero, Carry, Overflow, Negative} !== {1'b0, 16'h0030, 4'b0000}) begin
                errors++;
                $display("FAIL hold cyc%0d: got vld=%b out=%h zcvn=%b%b%b%b, want vld=0 out=0030 zcvn=0000",
                         i, out_valid, Out, Zero, Carry, Overflow, Negative);
            end
        end
    endtask

    task automatic test_reset_inflight();
        vec_t v [] = '{
            '{16'h7FFF, 16'h0001, OP_ADD, 16'h8000, 4'b0011}
        };
        run_table("pre_rst", v, 1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; A = 16'hFFFF; B = 16'h0001; control = OP_ADD;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, Out, Zero, Carry, Overflow, Negative} !== 21'h0) begin
            errors++;
            $display("FAIL rst_inflight: got vld=%b out=%h zcvn=%b%b%b%b, want vld=0 out=0000 zcvn=0000",
                     out_valid, Out, Zero, Carry, Overflow, Negative);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_boundary();
        test_slt_sll();
        test_back_to_back();
        test_reset_inflight();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
